// File: rtl/seg_chain_pkg.sv
// seg_chain_pkg: shared constants for the 7-segment chain driver.
//   - FSM state encodings (IDLE, CONVERT, SHIFT, LATCH)
//   - segment patterns, bit order {dp,g,f,e,d,c,b,a}, active high
//   - seg_of(): maps a nibble to its segment pattern
package seg_chain_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_LATCH   = 2'd3;

    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ERR_E = 8'h79;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        return SEG_HEX[d];
    endfunction

endpackage

// File: rtl/seg_chain_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//   One bit is consumed per cycle; DATA_WIDTH cycles after start.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load bin and begin conversion
//   bin        binary input (sampled on start)
//   done       high during the final conversion cycle
//   bcd        result of the current step; the final BCD value while done=1
module bin2bcd_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     bin,
    output logic                      done,
    output logic [NUM_DIGITS*4-1:0]   bcd
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0]   sh;
    logic [NUM_DIGITS*4-1:0] acc;
    logic [NUM_DIGITS*4-1:0] adj;
    logic [CW-1:0]           cnt;
    logic                    busy;

    // Add-3 on every digit >= 5, then shift the next binary bit in.
    // bcd is exposed combinationally so the caller can take the final
    // value on the same edge that completes the last step.
    always_comb begin
        adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
        bcd = (adj << 1) | {{(NUM_DIGITS*4-1){1'b0}}, sh[DATA_WIDTH-1]};
    end

    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            acc  <= '0;
            cnt  <= CW'(DATA_WIDTH);
            busy <= 1'b1;
        end else if (busy) begin
            sh  <= sh << 1;
            acc <= bcd;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_chain_driver.sv
// seg_chain_driver: converts a word to NUM_DIGITS 7-segment patterns and
// shifts them into a chain of shift-register displays, then latches.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_data, i_2s_comp, i_hex  value, signed flag, hex/decimal select
//   i_valid / o_ready         request handshake (ready only in IDLE)
//   o_done                    high while idle
//   o_sr_data/clk/latch       serial data, shift clock, storage latch
// Build option: define SEG_CHAIN_DRIVER_LZB_EN to blank leading zeros.
module seg_chain_driver
    import seg_chain_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_2s_comp,
    input  logic                  i_hex,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch
);

    // Decimal digits ever produced by DATA_WIDTH bits (8^k < 10^k).
    localparam int IW   = (DATA_WIDTH + 2) / 3;
    localparam int SD   = (NUM_DIGITS > IW) ? NUM_DIGITS : IW;
    localparam int SR_W = 8 * NUM_DIGITS;
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW   = $clog2(SR_W);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] mag;
    logic                  neg;
    logic                  hex;
    logic [SR_W-1:0]       sr;
    logic                  sr_data;
    logic                  sr_clk;
    logic                  sr_latch;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;

    logic                  accept;
    logic                  neg_in;
    logic [DATA_WIDTH-1:0] mag_in;
    logic                  bcd_done;
    logic [IW*4-1:0]       bcd;
    logic                  div_last;
    logic                  bit_last;

    logic [SD*4-1:0]              src;
    logic [NUM_DIGITS-1:0][7:0]   segs;
    logic [SR_W-1:0]              seg_flat;
    logic                         ovf;
    int                           limit;

    assign accept   = (state == ST_IDLE) && i_valid;
    assign neg_in   = i_2s_comp && i_data[DATA_WIDTH-1];
    // The most negative value negates to itself, which read unsigned is
    // exactly its magnitude.
    assign mag_in   = neg_in ? -i_data : i_data;
    assign div_last = (div_cnt == DW'(CLK_DIV - 1));
    assign bit_last = (bit_cnt == BW'(SR_W - 1));

    bin2bcd_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DIGITS (IW)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept && !i_hex),
        .bin   (mag_in),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Digit source (hex nibbles or BCD), overflow detection and segment
    // pattern assembly. Digit 0 is the rightmost display.
    always_comb begin
        src = '0;
        if (hex)
            src[DATA_WIDTH-1:0] = mag;
        else
            src[IW*4-1:0] = bcd;

        // A negative value gives up the leftmost digit to the minus sign.
        limit = neg ? NUM_DIGITS - 1 : NUM_DIGITS;
        ovf   = 1'b0;
        for (int i = 0; i < SD; i++) begin
            if (i >= limit && src[i*4 +: 4] != 4'd0)
                ovf = 1'b1;
        end

        for (int i = 0; i < NUM_DIGITS; i++)
            segs[i] = seg_of(src[i*4 +: 4]);

`ifdef SEG_CHAIN_DRIVER_LZB_EN
        begin : lzb
            int msd;
            msd = 0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (src[i*4 +: 4] != 4'd0)
                    msd = i;
            end
            for (int i = 1; i < NUM_DIGITS; i++) begin
                if (i > msd)
                    segs[i] = SEG_BLANK;
            end
            if (neg && msd < NUM_DIGITS - 1)
                segs[msd + 1] = SEG_MINUS;
        end
`else
        // No overflow means the leftmost digit is zero when negative.
        if (neg)
            segs[NUM_DIGITS-1] = SEG_MINUS;
`endif

        if (ovf) begin
            segs    = '0;
            segs[0] = SEG_ERR_E;
        end
    end

    assign seg_flat = segs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mag      <= '0;
            neg      <= 1'b0;
            hex      <= 1'b0;
            sr       <= '0;
            sr_data  <= 1'b0;
            sr_clk   <= 1'b0;
            sr_latch <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        state <= ST_CONVERT;
                        mag   <= mag_in;
                        neg   <= neg_in;
                        hex   <= i_hex;
                    end
                end
                ST_CONVERT: begin
                    if (hex || bcd_done) begin
                        // First bit goes out while the shift clock is low.
                        state   <= ST_SHIFT;
                        sr_data <= seg_flat[SR_W-1];
                        sr      <= {seg_flat[SR_W-2:0], 1'b0};
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!sr_clk) begin
                            sr_clk <= 1'b1;
                        end else begin
                            // Falling edge: advance data while clock is low.
                            sr_clk <= 1'b0;
                            if (bit_last) begin
                                state    <= ST_LATCH;
                                sr_data  <= 1'b0;
                                sr_latch <= 1'b1;
                            end else begin
                                sr_data <= sr[SR_W-1];
                                sr      <= sr << 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin // ST_LATCH
                    if (div_last) begin
                        sr_latch <= 1'b0;
                        div_cnt  <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_ready    = (state == ST_IDLE);
    assign o_done     = (state == ST_IDLE);
    assign o_sr_data  = sr_data;
    assign o_sr_clk   = sr_clk;
    assign o_sr_latch = sr_latch;

endmodule

// File: doc/seg_chain_driver.md
SEG_CHAIN_DRIVER -- requirements
Module: seg_chain_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, input word width (>=4).
REQ-002 SHALL have parameter NUM_DIGITS, default 5, number of chained 7-seg displays (>=2).
REQ-003 SHALL have parameter CLK_DIV, default 2, clk cycles per sr-clock half-period (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_data  input  DATA_WIDTH  value to display.
REQ-007 SHALL have port i_2s_comp  input  1  i_data is two's complement.
REQ-008 SHALL have port i_hex  input  1  1 = hexadecimal digits, 0 = decimal.
REQ-009 SHALL have port i_valid  input  1  request; o_ready  output  1  accepting.
REQ-010 SHALL have port o_done  output  1  high only while idle (no conversion/shift in progress).
REQ-011 SHALL have ports o_sr_data, o_sr_clk, o_sr_latch  output  1 each  serial data, shift clock, storage latch.

Function
REQ-012 SHALL use FSM states IDLE, CONVERT, SHIFT, LATCH; IDLE->CONVERT on i_valid&&o_ready; CONVERT->SHIFT when digits ready; SHIFT->LATCH after last bit; LATCH->IDLE after latch pulse.
REQ-013 SHALL assert o_ready and o_done only in IDLE; i_data/i_2s_comp/i_hex captured on the accepting edge; inputs ignored elsewhere.
REQ-014 SHALL, when i_2s_comp=1 and i_data MSB=1, display the magnitude (two's complement negation) with a minus pattern; most-negative value negates to its unsigned magnitude.
REQ-015 SHALL in hex mode produce digits in 1 CONVERT cycle; in decimal mode in exactly DATA_WIDTH CONVERT cycles (sequential double dabble).
REQ-016 SHALL, if the magnitude needs more than NUM_DIGITS digits (NUM_DIGITS-1 if negative), show overflow: 'E' on digit 0, all other digits blank.
REQ-017 SHALL shift 8 bits per digit, segment byte order {dp,g,f,e,d,c,b,a} MSB first, active-high segments, dp always 0, most significant digit first (8*NUM_DIGITS bits total).
REQ-018 SHALL change o_sr_data only while o_sr_clk is low; each bit: o_sr_clk low CLK_DIV cycles then high CLK_DIV cycles.
REQ-019 SHALL drive o_sr_latch high for CLK_DIV cycles in LATCH with o_sr_clk low, then return to IDLE next cycle.
REQ-020 SHALL, without leading-zero blanking, place minus on the leftmost digit (overwriting it; overflow rule REQ-016 guarantees it is zero).
REQ-021 SHALL have o_sr_clk, o_sr_latch, o_sr_data low in IDLE and CONVERT.

Reset
REQ-022 SHALL on rst force IDLE, o_ready=1, o_done=1, o_sr_data=0, o_sr_clk=0, o_sr_latch=0, clear counters, digit and shift registers.
REQ-023 SHALL abandon any conversion or shift when rst asserts mid-operation; no latch pulse issued.

Configuration
REQ-024 SHALL, with SEG_CHAIN_DRIVER_LZB_EN defined, blank leading zero digits (pattern 0x00) except digit 0, and place minus immediately left of the most significant non-zero digit.
REQ-025 SHALL, without SEG_CHAIN_DRIVER_LZB_EN, display all leading zeros and follow REQ-020.

Structure
REQ-026 SHALL put the FSM state enum and segment constants (0-F, MINUS=0x40, BLANK=0x00, ERR_E=0x79) in package seg_chain_pkg.
REQ-027 SHALL implement decimal conversion in sub-module bin2bcd_seq (start/done handshake, DATA_WIDTH and NUM_DIGITS parameters).

Verification
REQ-028 SHALL cover: defaults, i_data=16'd1234, i_2s_comp=0, i_hex=0 -> 40 bits 0x3F,0x06,0x5B,0x4F,0x66 (LZB off); done low 16+160+2+ cycles.
REQ-029 SHALL cover: i_data=16'hFFFF, i_2s_comp=1, decimal, LZB on -> blank,blank,blank,MINUS,0x06.
REQ-030 SHALL cover: i_data=16'hBEEF, i_hex=1 -> 0x3F,0x7C,0x79,0x79,0x71; CONVERT lasts 1 cycle.
REQ-031 SHALL cover: i_data=16'h8000, i_2s_comp=1, NUM_DIGITS=5, decimal -> 32768 needs 5 digits + sign -> overflow BLANKx4, ERR_E.
REQ-032 SHALL cover: rst asserted at bit 17 of SHIFT -> all outputs reset next edge, no latch pulse; new i_valid then accepted normally.
REQ-033 SHALL cover: i_valid held high during SHIFT with changing i_data -> ignored; o_ready re-asserts only after latch pulse.
